// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide engine.
//   Multiply uses radix-2 shift-add and divide uses a restoring divider.
//   Both work on operand magnitudes through one shared adder, and FIX
//   restores the signs afterwards.
//   FIX has two phases: negate, then select and register the result.
//   The full latency is therefore start edge E0 -> done in the cycle after E0+XLEN+2.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset; aborts any operation
//   start  in   launch request (accepted in IDLE or DONE)
//   func3  in   MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU select
//   a, b   in   rs1 / rs2 operands
//   busy   out  high in CALC and FIX
//   done   out  one-cycle pulse when result is valid
//   result out  operation result, held until the next done
// Optional macro MULDIV_EARLY_OUT_EN: b==0, or a multiply with a==0, skips CALC.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   count_q;
  logic            fix_q;
  logic [2:0]      op_q;
  logic            sa_q, sb_q, bz_q;
  logic [XLEN-1:0] mb_q, hi_q, lo_q;
  logic            busy_q, done_q;
  logic [XLEN-1:0] result_q;

  // Operand decode for capture
  logic            a_signed, b_signed, sa_d, sb_d, skip_d, accept;
  logic [XLEN-1:0] ma_d, mb_d;

  always_comb begin
    a_signed = (func3 != 3'b011) && (func3 != 3'b101) && (func3 != 3'b111);
    b_signed = (func3 == 3'b000) || (func3 == 3'b001) ||
               (func3 == 3'b100) || (func3 == 3'b110);
    sa_d     = a_signed & a[XLEN-1];
    sb_d     = b_signed & b[XLEN-1];
    ma_d     = sa_d ? (~a + 1'b1) : a;
    mb_d     = sb_d ? (~b + 1'b1) : b;
    accept   = start && ((state_q == IDLE) || (state_q == DONE));
  end

`ifdef MULDIV_EARLY_OUT_EN
  assign skip_d = (b == '0) || (!func3[2] && (a == '0));
`else
  assign skip_d = 1'b0;
`endif

  // Shared adder. Multiply: hi + |b|. Divide: {rem,msb} - |b| done as
  // XLEN+1 bit add of the complement; the carry out means "no borrow".
  logic [XLEN:0]   shifted, add_x, add_y;
  logic            add_ci;
  logic [XLEN+1:0] add_s;

  always_comb begin
    shifted = {hi_q, lo_q[XLEN-1]};
    if (op_q[2]) begin
      add_x  = shifted;
      add_y  = ~{1'b0, mb_q};
      add_ci = 1'b1;
    end else begin
      add_x  = {1'b0, hi_q};
      add_y  = {1'b0, mb_q};
      add_ci = 1'b0;
    end
    add_s = {1'b0, add_x} + {1'b0, add_y} + {{(XLEN+1){1'b0}}, add_ci};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      fix_q    <= 1'b0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      bz_q     <= 1'b0;
      mb_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        op_q    <= func3;
        sa_q    <= sa_d;
        sb_q    <= sb_d;
        bz_q    <= (b == '0);
        mb_q    <= mb_d;
        count_q <= '0;
        fix_q   <= 1'b0;
        busy_q  <= 1'b1;
        state_q <= skip_d ? FIX : CALC;
        // Early-out preloads what the full iteration would have produced:
        // divide by zero -> quotient all ones, remainder |a|; multiply -> 0.
        if (skip_d) begin
          hi_q <= func3[2] ? ma_d : '0;
          lo_q <= func3[2] ? '1 : '0;
        end else begin
          hi_q <= '0;
          lo_q <= ma_d;
        end
      end else begin
        case (state_q)
          IDLE: ;
          CALC: begin
            if (op_q[2]) begin
              hi_q <= add_s[XLEN+1] ? add_s[XLEN-1:0] : shifted[XLEN-1:0];
              lo_q <= {lo_q[XLEN-2:0], add_s[XLEN+1]};
            end else if (lo_q[0]) begin
              {hi_q, lo_q} <= {add_s[XLEN:0], lo_q[XLEN-1:1]};
            end else begin
              {hi_q, lo_q} <= {1'b0, hi_q, lo_q[XLEN-1:1]};
            end
            count_q <= count_q + CW'(1);
            if (count_q == CW'(XLEN - 1)) state_q <= FIX;
          end
          FIX: begin
            if (!fix_q) begin
              fix_q <= 1'b1;
              if (!op_q[2]) begin
                if (sa_q ^ sb_q) {hi_q, lo_q} <= ~{hi_q, lo_q} + 1'b1;
              end else begin
                // Divide by zero keeps the all-ones quotient regardless of signs.
                if ((sa_q ^ sb_q) && !bz_q) lo_q <= ~lo_q + 1'b1;
                if (sa_q) hi_q <= ~hi_q + 1'b1;
              end
            end else begin
              result_q <= ((op_q == 3'b000) || (op_q[2:1] == 2'b10)) ? lo_q : hi_q;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: expected results are queued at launch and
// compared when done is observed, together with the start-to-done latency.
module tb_muldiv_unit;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 34;
`endif
  localparam int FLAT = 34;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  func3 = 3'b000;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int e0 = 0;
  logic [31:0] sbq[$];

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .func3(func3),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive an op in the current cycle; it is captured at the next rising edge.
  task automatic launch(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp);
    func3 = f; a = x; b = y; start = 1'b1;
    sbq.push_back(exp);
    @(posedge clk); #1;
    e0 = cyc;
    start = 1'b0;
    a = $urandom; b = $urandom; func3 = 3'($urandom);
    chk("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_done(input string tag, input int lat);
    int t = 0;
    logic [31:0] exp;
    while (done !== 1'b1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_lat"}, 32'(cyc - e0), 32'(lat));
    if (sbq.size() > 0) begin
      exp = sbq.pop_front();
      chk({tag, "_res"}, result, exp);
    end else begin
      chk({tag, "_queue"}, 32'd0, 32'd1);
    end
  endtask

  task automatic op(input string tag, input logic [2:0] f, input logic [31:0] x,
                    input logic [31:0] y, input logic [31:0] exp, input int lat);
    @(negedge clk);
    launch(f, x, y, exp);
    wait_done(tag, lat);
  endtask

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    op("mulhu_pre", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, FLAT);

    // Abort mid-CALC with reset
    @(negedge clk);
    launch(3'b000, 32'd9, 32'd9, 32'd81);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    sbq.delete();
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);

    op("mul", 3'b000, 32'd7, 32'd6, 32'd42, FLAT);
    op("mulh", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, FLAT);
    op("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, FLAT);
    op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, FLAT);
    op("div", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, FLAT);
    op("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, FLAT);
    op("divu", 3'b101, 32'd100, 32'd7, 32'd14, FLAT);
    op("remu", 3'b111, 32'd100, 32'd7, 32'd2, FLAT);
    op("div0", 3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, ZLAT);
    op("rem0", 3'b110, 32'd5, 32'd0, 32'd5, ZLAT);
    op("div0_neg", 3'b100, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, ZLAT);
    op("rem0_neg", 3'b110, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, ZLAT);
    op("divu0", 3'b101, 32'd1234, 32'd0, 32'hFFFFFFFF, ZLAT);
    op("mul_a0", 3'b000, 32'd0, 32'd9, 32'd0, ZLAT);
    op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, FLAT);
    op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, FLAT);
    op("mul_neg", 3'b000, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, FLAT);

    // start during busy is ignored
    @(negedge clk);
    launch(3'b101, 32'd100, 32'd7, 32'd14);
    repeat (5) @(negedge clk);
    func3 = 3'b000; a = 32'd3; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_mid", {31'b0, busy}, 32'd1);
    wait_done("ignore", FLAT);

    // Back-to-back: start held in the DONE cycle
    launch(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    wait_done("b2b", FLAT);
    @(posedge clk); #1;
    chk("done_pulse", {31'b0, done}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("result_hold", result, 32'hFFFFFFFE);
    chk("idle_busy", {31'b0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
